// File: rtl/spinvaders_pkg.sv
// Shared types and default timing constants for the space-invaders input conditioning.
package spinvaders_pkg;

  // Debouncer state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_P = 2'd1,
    HELD   = 2'd2,
    WAIT_R = 2'd3
  } db_state_e;

  // Default timing at 100 MHz: 5 ms debounce, 60 Hz game tick, 15-tick fire cooldown
  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 500000;
  localparam int unsigned DEF_TICK_CYCLES          = 1666667;
  localparam int unsigned DEF_SHOOT_COOLDOWN_TICKS = 15;

endpackage

// File: rtl/spinvaders_input_ctrl_if.sv
// Button inputs, run control and game-SM strobes between the board and the input controller.
interface spinvaders_input_ctrl_if;

  logic btnL_raw;
  logic btnR_raw;
  logic btnF_raw;
  logic game_en;
  logic game_tick;
  logic L_out;
  logic R_out;
  logic shoot_out;
  logic shot_ready;

  // Board / game side: drives buttons and run control, consumes strobes
  modport master (
    output btnL_raw, btnR_raw, btnF_raw, game_en,
    input  game_tick, L_out, R_out, shoot_out, shot_ready
  );

  // Input controller side
  modport slave (
    input  btnL_raw, btnR_raw, btnF_raw, game_en,
    output game_tick, L_out, R_out, shoot_out, shot_ready
  );

endinterface

// File: rtl/spinvaders_debouncer.sv
// Two-flop synchroniser plus press/release debounce FSM for one active-high button.
module spinvaders_debouncer
  import spinvaders_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]   sync_q;
  logic         sync;
  db_state_e    state;
  logic [CW-1:0] count;

  assign sync = sync_q[1];

  // Bring the asynchronous button into the Clk domain
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], raw};
  end

  // Debounce FSM; level and press are registered alongside the state
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync) begin
            state <= WAIT_P;
            count <= '0;
          end
        end
        WAIT_P: begin
          if (!sync) begin
            state <= IDLE;
          end else if (count == CNT_LAST) begin
            state <= HELD;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        HELD: begin
          if (!sync) begin
            state <= WAIT_R;
            count <= '0;
          end
        end
        WAIT_R: begin
          if (sync) begin
            state <= HELD;
          end else if (count == CNT_LAST) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/spinvaders_input_ctrl.sv
// Debounces the three buttons, generates the game tick and emits tick-aligned move/fire pulses.
module spinvaders_input_ctrl
  import spinvaders_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_CYCLES          = DEF_TICK_CYCLES,
  parameter int unsigned SHOOT_COOLDOWN_TICKS = DEF_SHOOT_COOLDOWN_TICKS
) (
  input logic              Clk,
  input logic              reset_n,
  spinvaders_input_ctrl_if.slave bus
);

  localparam int unsigned TCW  = $clog2(TICK_CYCLES);
  localparam int unsigned CDW  = (SHOOT_COOLDOWN_TICKS > 0) ? $clog2(SHOOT_COOLDOWN_TICKS + 1) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_CYCLES - 1);
  localparam logic [CDW-1:0] CD_LOAD   = CDW'(SHOOT_COOLDOWN_TICKS);

  logic lvl_l, lvl_r, lvl_f;
  logic press_f;
  logic unused_press_l, unused_press_r;

  logic [TCW-1:0] tick_count;
  logic           tick_c;
  logic [CDW-1:0] cooldown;
  logic           pending;

  logic game_tick_q, l_q, r_q, shoot_q, shot_ready_q;

  spinvaders_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .Clk(Clk), .reset_n(reset_n), .raw(bus.btnL_raw), .level(lvl_l), .press(unused_press_l)
  );

  spinvaders_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .Clk(Clk), .reset_n(reset_n), .raw(bus.btnR_raw), .level(lvl_r), .press(unused_press_r)
  );

  spinvaders_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_f (
    .Clk(Clk), .reset_n(reset_n), .raw(bus.btnF_raw), .level(lvl_f), .press(press_f)
  );

  // Fire uses only the press strobe, so a held button yields a single shot
  logic unused_lvl_f;
  assign unused_lvl_f = lvl_f;

  assign tick_c = (tick_count == TICK_LAST) && bus.game_en;

  // Free-running frame counter, frozen while paused
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= '0;
    end else if (bus.game_en) begin
      tick_count <= (tick_count == TICK_LAST) ? '0 : tick_count + TCW'(1);
    end
  end

  // Tick-aligned movement pulses; opposing directions cancel
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      game_tick_q <= 1'b0;
      l_q         <= 1'b0;
      r_q         <= 1'b0;
    end else begin
      game_tick_q <= tick_c;
      l_q         <= tick_c & lvl_l & ~lvl_r;
      r_q         <= tick_c & lvl_r & ~lvl_l;
    end
  end

  // Fire arbitration: latch a press while ready, fire on a tick, then count down the cooldown
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= 1'b0;
      cooldown     <= '0;
      shoot_q      <= 1'b0;
      shot_ready_q <= 1'b1;
    end else begin
      shoot_q <= 1'b0;
      if (!bus.game_en) begin
        pending <= 1'b0;
      end else if (tick_c) begin
        if ((cooldown == '0) && (pending || press_f)) begin
          shoot_q      <= 1'b1;
          pending      <= 1'b0;
          cooldown     <= CD_LOAD;
          shot_ready_q <= (CD_LOAD == '0);
        end else if (cooldown != '0) begin
          cooldown     <= cooldown - CDW'(1);
          shot_ready_q <= (cooldown == CDW'(1));
        end
      end else if (press_f && (cooldown == '0)) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.game_tick  = game_tick_q;
  assign bus.L_out      = l_q;
  assign bus.R_out      = r_q;
  assign bus.shoot_out  = shoot_q;
  assign bus.shot_ready = shot_ready_q;

endmodule

// File: tb/tb_spinvaders_input_ctrl.sv
// Directed + randomized bench for spinvaders_input_ctrl with a behavioural reference model.
module tb_spinvaders_input_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TICK = 10;
  localparam int unsigned CD   = 3;

  logic clk;
  logic rst_n;

  spinvaders_input_ctrl_if bus();

  spinvaders_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES(TICK),
    .SHOOT_COOLDOWN_TICKS(CD)
  ) dut (
    .Clk(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Model: a button's level flips after DEB+1 consecutive synchronised samples disagreeing with it
  bit          m_s1[3], m_s2[3], m_lvl[3], m_press[3];
  int unsigned m_run[3];
  int unsigned m_tcnt, m_cd;
  bit          m_pend, m_tick, m_l, m_r, m_shoot, m_ready;

  int ticks_seen, l_seen, r_seen, shots_seen;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0; m_run[b] = 0;
    end
    m_tcnt = 0; m_cd = 0; m_pend = 0;
    m_tick = 0; m_l = 0; m_r = 0; m_shoot = 0; m_ready = 1;
  endtask

  task automatic model_step();
    bit raw[3];
    bit itick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw[0] = bus.btnL_raw; raw[1] = bus.btnR_raw; raw[2] = bus.btnF_raw;
    itick  = (m_tcnt == TICK - 1) && bus.game_en;
    m_tick = itick;
    m_l    = itick && m_lvl[0] && !m_lvl[1];
    m_r    = itick && m_lvl[1] && !m_lvl[0];
    m_shoot = 0;
    if (!bus.game_en) m_pend = 0;
    else if (itick) begin
      if (m_cd == 0 && (m_pend || m_press[2])) begin
        m_shoot = 1; m_pend = 0; m_cd = CD;
      end else if (m_cd > 0) m_cd--;
    end else if (m_press[2] && m_cd == 0) m_pend = 1;
    m_ready = (m_cd == 0);
    if (bus.game_en) m_tcnt = (m_tcnt + 1) % TICK;
    for (int b = 0; b < 3; b++) begin
      m_press[b] = 0;
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB + 1) begin
          m_lvl[b] = m_s2[b]; m_run[b] = 0; m_press[b] = m_s2[b];
        end
      end else m_run[b] = 0;
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  task automatic check_all();
    chk("game_tick",  bus.game_tick,  m_tick);
    chk("L_out",      bus.L_out,      m_l);
    chk("R_out",      bus.R_out,      m_r);
    chk("shoot_out",  bus.shoot_out,  m_shoot);
    chk("shot_ready", bus.shot_ready, m_ready);
  endtask

  // Advance n cycles: model at posedge, compare at negedge, tally observed pulses
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      ticks_seen += int'(bus.game_tick);
      l_seen     += int'(bus.L_out);
      r_seen     += int'(bus.R_out);
      shots_seen += int'(bus.shoot_out);
    end
  endtask

  task automatic clr_counts();
    ticks_seen = 0; l_seen = 0; r_seen = 0; shots_seen = 0;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge
  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_tick"},  bus.game_tick,  1'b0);
    chk({tag, "_L"},     bus.L_out,      1'b0);
    chk({tag, "_R"},     bus.R_out,      1'b0);
    chk({tag, "_shoot"}, bus.shoot_out,  1'b0);
    chk({tag, "_ready"}, bus.shot_ready, 1'b1);
    @(negedge clk);
    bus.btnF_raw = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int hold[3];
    int guard;
    n_cmp = 0; n_bad = 0;
    clr_counts();
    rst_n = 1'b0;
    bus.btnL_raw = 1'b0; bus.btnR_raw = 1'b0; bus.btnF_raw = 1'b0;
    bus.game_en = 1'b1;
    model_reset();
    cyc(3);
    chk("rst_ready", bus.shot_ready, 1'b1);
    chk("rst_tick",  bus.game_tick,  1'b0);
    rst_n = 1'b1;

    // 1: idle running, one tick per 10 cycles
    clr_counts();
    cyc(30);
    chk_int("idle_ticks", ticks_seen, 3);
    chk_int("idle_moves", l_seen + r_seen + shots_seen, 0);

    // 2: short glitch is rejected, sustained press moves left
    bus.btnL_raw = 1'b1;
    cyc(2);
    bus.btnL_raw = 1'b0;
    clr_counts();
    cyc(20);
    chk_int("glitch_L", l_seen, 0);
    bus.btnL_raw = 1'b1;
    cyc(40);

    // 3: both held cancel, releasing right resumes left
    bus.btnR_raw = 1'b1;
    cyc(8);
    clr_counts();
    cyc(30);
    chk_int("both_L", l_seen, 0);
    chk_int("both_R", r_seen, 0);
    bus.btnR_raw = 1'b0;
    clr_counts();
    cyc(30);
    chk_int("resume_L", (l_seen > 0) ? 1 : 0, 1);
    bus.btnL_raw = 1'b0;
    cyc(20);

    // 4: single shot, discarded re-press during cooldown, second shot once ready
    clr_counts();
    bus.btnF_raw = 1'b1;
    cyc(10);
    bus.btnF_raw = 1'b0;
    cyc(15);
    chk_int("shot1", shots_seen, 1);
    clr_counts();
    bus.btnF_raw = 1'b1;
    cyc(10);
    bus.btnF_raw = 1'b0;
    cyc(10);
    chk_int("shot_discard", shots_seen, 0);
    guard = 0;
    while (!bus.shot_ready && guard < 100) begin cyc(1); guard++; end
    chk("ready_return", bus.shot_ready, 1'b1);
    clr_counts();
    bus.btnF_raw = 1'b1;
    cyc(10);
    bus.btnF_raw = 1'b0;
    cyc(15);
    chk_int("shot2", shots_seen, 1);
    cyc(40);

    // 5: fire held for 50 ticks gives one shot
    clr_counts();
    bus.btnF_raw = 1'b1;
    cyc(500);
    chk_int("held_fire", shots_seen, 1);
    bus.btnF_raw = 1'b0;
    cyc(40);

    // 6a: reset during cooldown
    clr_counts();
    bus.btnF_raw = 1'b1;
    guard = 0;
    while (!bus.shoot_out && guard < 40) begin cyc(1); guard++; end
    chk("shot_before_rst", bus.shoot_out, 1'b1);
    cyc(5);
    async_reset_check("rst_cd");
    clr_counts();
    cyc(40);
    chk_int("no_shot_after_rst", shots_seen, 0);

    // 6b: reset with a fire pending
    bus.btnF_raw = 1'b1;
    guard = 0;
    while (!m_pend && guard < 20) begin cyc(1); guard++; end
    chk("pend_reached", m_pend, 1'b1);
    async_reset_check("rst_pend");
    clr_counts();
    cyc(40);
    chk_int("no_shot_after_rst2", shots_seen, 0);

    // Pause: counter frozen, phase resumes from the held count
    cyc(4);
    bus.game_en = 1'b0;
    clr_counts();
    cyc(30);
    chk_int("pause_ticks", ticks_seen, 0);
    bus.game_en = 1'b1;
    cyc(30);

    // Randomized buttons and pauses against the model
    for (int b = 0; b < 3; b++) hold[b] = int'($urandom_range(1, 25));
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          hold[b] = int'($urandom_range(1, 25));
          case (b)
            0: bus.btnL_raw = ~bus.btnL_raw;
            1: bus.btnR_raw = ~bus.btnR_raw;
            default: bus.btnF_raw = ~bus.btnF_raw;
          endcase
        end
      end
      if ($urandom_range(0, 99) < 3) bus.game_en = ~bus.game_en;
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
